// File: rtl/uart_peek_sweeper.sv
// Sweeps addr_lo..addr_hi by step and sends one UART frame {id,addr}, LSB byte first, per address.
// First start bit on tx the cycle after an accepted start; start is ignored while busy and abort lands at a frame boundary.
module uart_peek_sweeper #(
  parameter int CLK_DIV    = 434,
  parameter int ID_W       = 8,
  parameter int ADDR_W     = 32,
  parameter int PARITY_EN  = 0,
  parameter int STOP_BITS  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ID_W-1:0]   id,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  input  logic [ADDR_W-1:0] step,
  output logic              tx,
  output logic              bit_tick,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  localparam int FW = ID_W + ADDR_W;
  localparam int NB = FW / 8;
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     div_cnt;
  logic [2:0]        bit_idx;
  logic              stop_idx;
  logic [BW-1:0]     byte_idx;
  logic [GW-1:0]     gap_cnt;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q, hi_q, step_q;
  logic [FW-1:0]     frame_sh;
  logic [7:0]        byte_q;
  logic              abort_q, empty_q;

  logic              accept, bit_end, byte_end, frame_end, sweep_end;
  logic [ADDR_W:0]   nxt;
  logic [FW-1:0]     first_frame, next_frame;

  assign accept      = (state == IDLE) && start && !busy;
  assign bit_end     = (div_cnt == DIV_LAST);
  assign byte_end    = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
  assign frame_end   = byte_end && (byte_idx == BYTE_LAST);
  // One extra bit so a carry out of ADDR_W compares as larger than any addr_hi.
  assign nxt         = {1'b0, addr_q} + {1'b0, step_q};
  assign sweep_end   = (nxt > {1'b0, hi_q}) || (step_q == '0) || abort_q || (busy && abort);
  assign first_frame = {id, addr_lo};
  assign next_frame  = {id_q, nxt[ADDR_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    bit_tick  = 1'b0;
    case (state)
      IDLE:   if (accept && (addr_lo <= addr_hi)) state_nxt = START;
      START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx = byte_q[bit_idx];
        if (bit_end && (bit_idx == 3'd7)) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        tx = ^byte_q;
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        if (byte_end) begin
          if (!frame_end)          state_nxt = START;
          else if (sweep_end)      state_nxt = IDLE;
          else if (GAP_CYCLES > 0) state_nxt = GAP;
          else                     state_nxt = START;
        end
      end
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = START;
      default: state_nxt = IDLE;
    endcase
    if ((state inside {START, DATA, PARITY, STOP}) && (div_cnt == '0)) bit_tick = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      byte_idx  <= '0;
      gap_cnt   <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      hi_q      <= '0;
      step_q    <= '0;
      frame_sh  <= '0;
      byte_q    <= '0;
      abort_q   <= 1'b0;
      empty_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (busy && abort) abort_q <= 1'b1;
      // Empty range: busy for one cycle, then done.
      if (empty_q) begin
        empty_q <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b1;
      end
      if (accept) begin
        id_q      <= id;
        addr_q    <= addr_lo;
        hi_q      <= addr_hi;
        step_q    <= step;
        frame_cnt <= '0;
        abort_q   <= 1'b0;
        busy      <= 1'b1;
        div_cnt   <= '0;
        bit_idx   <= '0;
        stop_idx  <= 1'b0;
        byte_idx  <= '0;
        gap_cnt   <= '0;
        byte_q    <= first_frame[7:0];
        frame_sh  <= first_frame >> 8;
        empty_q   <= (addr_lo > addr_hi);
      end
      if (state inside {START, DATA, PARITY, STOP}) div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
      if ((state == DATA) && bit_end) bit_idx <= bit_idx + 3'd1;
      if ((state == STOP) && bit_end) stop_idx <= !byte_end;
      if (byte_end) begin
        if (!frame_end) begin
          byte_idx <= byte_idx + 1'b1;
          byte_q   <= frame_sh[7:0];
          frame_sh <= frame_sh >> 8;
        end else begin
          byte_idx <= '0;
          if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
          if (sweep_end) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            addr_q   <= nxt[ADDR_W-1:0];
            byte_q   <= next_frame[7:0];
            frame_sh <= next_frame >> 8;
          end
        end
      end
      if (state == GAP) gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_peek_sweeper.sv
// Bench for uart_peek_sweeper: per-cycle trace model for two parameter sets plus literal pins.
module tb_uart_peek_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_b, abort;
  logic [7:0]  id;
  logic [31:0] lo, hi, step;
  logic        tx_a, tick_a, busy_a, done_a, tx_b, tick_b, busy_b, done_b;
  logic [15:0] fc_a, fc_b;

  uart_peek_sweeper #(.CLK_DIV(4), .ID_W(8), .ADDR_W(32), .PARITY_EN(0), .STOP_BITS(1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .id(id), .addr_lo(lo), .addr_hi(hi),
    .step(step), .tx(tx_a), .bit_tick(tick_a), .busy(busy_a), .done(done_a), .frame_cnt(fc_a));

  uart_peek_sweeper #(.CLK_DIV(4), .ID_W(8), .ADDR_W(32), .PARITY_EN(1), .STOP_BITS(2), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .id(id), .addr_lo(lo), .addr_hi(hi),
    .step(step), .tx(tx_b), .bit_tick(tick_b), .busy(busy_b), .done(done_b), .frame_cnt(fc_b));

  typedef struct packed {
    logic        tx;
    logic        tick;
    logic        busy;
    logic        done;
    logic [15:0] fc;
  } obs_t;

  obs_t        q_a[$], q_b[$];
  obs_t        ea, eb, aa, ab;
  logic [15:0] last_fc_a = 16'd0, last_fc_b = 16'd0;
  int          n_vec = 0, n_bad = 0;
  logic        cap_a [0:1023];
  logic        cap_b [0:1023];
  int          cyc_a = 1024, cyc_b = 1024;

  task automatic cmp(input string nm, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s t=%0t got tx=%b tick=%b busy=%b done=%b fc=%0d, want tx=%b tick=%b busy=%b done=%b fc=%0d",
                 nm, $time, act.tx, act.tick, act.busy, act.done, act.fc,
                 exp.tx, exp.tick, exp.busy, exp.done, exp.fc);
    end
  endtask

  task automatic lit(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input bit sel, input obs_t e);
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  // Expected per-cycle trace of a whole sweep, starting the cycle after acceptance.
  task automatic push_sweep(input bit sel, input int par, input int stops, input int gap,
                            input logic [7:0] fid, input logic [31:0] flo, input logic [31:0] fhi,
                            input logic [31:0] fstep, input int abort_after);
    logic [32:0] a, nx;
    logic [39:0] fr;
    logic [7:0]  by;
    bit          bits[$];
    int          n;
    if (flo > fhi) begin
      push(sel, '{1'b1, 1'b0, 1'b1, 1'b0, 16'd0});
      push(sel, '{1'b1, 1'b0, 1'b0, 1'b1, 16'd0});
      return;
    end
    a = {1'b0, flo};
    n = 0;
    forever begin
      fr = {fid, a[31:0]};
      bits.delete();
      for (int k = 0; k < 5; k++) begin
        by = fr[k*8 +: 8];
        bits.push_back(1'b0);
        for (int j = 0; j < 8; j++) bits.push_back(by[j]);
        if (par != 0) bits.push_back(^by);
        for (int s = 0; s < stops; s++) bits.push_back(1'b1);
      end
      foreach (bits[i])
        for (int c = 0; c < 4; c++) push(sel, '{bits[i], (c == 0), 1'b1, 1'b0, 16'(n)});
      n++;
      nx = a + {1'b0, fstep};
      if ((nx > {1'b0, fhi}) || (fstep == 0) || (n == abort_after)) begin
        push(sel, '{1'b1, 1'b0, 1'b0, 1'b1, 16'(n)});
        break;
      end
      for (int g = 0; g < gap; g++) push(sel, '{1'b1, 1'b0, 1'b1, 1'b0, 16'(n)});
      a = nx;
    end
  endtask

  always @(negedge clk) begin
    ea = (q_a.size() > 0) ? q_a.pop_front() : '{1'b1, 1'b0, 1'b0, 1'b0, last_fc_a};
    eb = (q_b.size() > 0) ? q_b.pop_front() : '{1'b1, 1'b0, 1'b0, 1'b0, last_fc_b};
    last_fc_a = ea.fc;
    last_fc_b = eb.fc;
    aa = '{tx_a, tick_a, busy_a, done_a, fc_a};
    ab = '{tx_b, tick_b, busy_b, done_b, fc_b};
    cmp("trace_a", aa, ea);
    cmp("trace_b", ab, eb);
    if (cyc_a < 1024) begin cap_a[cyc_a] = tx_a; cyc_a++; end
    if (cyc_b < 1024) begin cap_b[cyc_b] = tx_b; cyc_b++; end
  end

  task automatic go(input bit sel, input int par, input int stops, input int gap,
                    input logic [7:0] fid, input logic [31:0] flo, input logic [31:0] fhi,
                    input logic [31:0] fstep, input int abort_after);
    @(negedge clk); #1;
    id = fid; lo = flo; hi = fhi; step = fstep;
    push_sweep(sel, par, stops, gap, fid, flo, fhi, fstep, abort_after);
    if (sel) begin cyc_b = 1; start_b = 1'b1; end
    else     begin cyc_a = 1; start_a = 1'b1; end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input string nm, input bit sel, input int cnt0, input int bound, output int cyc);
    int c;
    c   = cnt0;
    cyc = -1;
    while (c < bound) begin
      @(negedge clk);
      c++;
      if ((sel ? done_b : done_a) === 1'b1) begin
        cyc = c;
        break;
      end
    end
    if (cyc < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s no done within %0d cycles", nm, bound);
    end
  endtask

  task automatic chk_byte_a(input int k, input logic [7:0] exp);
    logic [9:0] got;
    for (int j = 0; j < 10; j++) got[9-j] = cap_a[1 + k*40 + j*4 + 1];
    lit($sformatf("a_byte%0d", k), got, {1'b0, exp[0], exp[1], exp[2], exp[3], exp[4], exp[5], exp[6], exp[7], 1'b1});
  endtask

  int          cyc;
  logic [11:0] b0;
  logic [7:0]  exp_bytes [0:4];

  initial begin
    exp_bytes = '{8'h3C, 8'h02, 8'h00, 8'h00, 8'h03};
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    id = '0; lo = '0; hi = '0; step = '0;
    #3;
    lit("reset_tx", tx_a, 1);
    lit("reset_tick", tick_a, 0);
    lit("reset_busy", busy_a, 0);
    lit("reset_done", done_a, 0);
    lit("reset_fc", fc_a, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // abort while idle must not leak into the next sweep
    @(negedge clk); #1 abort = 1'b1;
    @(negedge clk); #1 abort = 1'b0;

    // 3-frame sweep with an ignored start while busy at cycle 100
    go(0, 0, 1, 0, 8'd3, 32'd572, 32'd574, 32'd1, 0);
    repeat (99) @(negedge clk);
    #1 lo = 32'd0; hi = 32'd100; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done("sweep3", 0, 99, 2000, cyc);
    lit("sweep3_done_cycle", cyc, 601);
    lit("sweep3_fc", fc_a, 3);
    for (int k = 0; k < 5; k++) chk_byte_a(k, exp_bytes[k]);

    // carry out of the address ends the sweep
    go(0, 0, 1, 0, 8'h55, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd4, 0);
    wait_done("carry", 0, 0, 1000, cyc);
    lit("carry_done_cycle", cyc, 201);
    lit("carry_fc", fc_a, 1);

    // step of zero sends exactly one frame
    go(0, 0, 1, 0, 8'h11, 32'd5, 32'd9, 32'd0, 0);
    wait_done("step0", 0, 0, 1000, cyc);
    lit("step0_fc", fc_a, 1);

    // abort mid-byte of frame 2 of a 10-frame sweep
    go(0, 0, 1, 0, 8'h01, 32'd0, 32'd9, 32'd1, 2);
    repeat (249) @(negedge clk);
    #1 abort = 1'b1;
    @(negedge clk); #1 abort = 1'b0;
    wait_done("abort", 0, 250, 3000, cyc);
    lit("abort_done_cycle", cyc, 401);
    lit("abort_fc", fc_a, 2);
    repeat (20) @(negedge clk);
    lit("abort_tx_idle", tx_a, 1);

    // parity + 2 stop bits, single frame
    go(1, 1, 2, 3, 8'h81, 32'h7, 32'h7, 32'd1, 0);
    wait_done("parity", 1, 0, 1000, cyc);
    lit("parity_done_cycle", cyc, 241);
    lit("parity_fc", fc_b, 1);
    for (int j = 0; j < 12; j++) b0[11-j] = cap_b[1 + j*4 + 1];
    lit("parity_byte0_bits", b0, 12'b0_11100000_1_11);
    lit("parity_id_byte_par", cap_b[1 + 4*48 + 9*4 + 1], 0);

    // two frames separated by a 3-cycle gap
    go(1, 1, 2, 3, 8'h10, 32'd0, 32'd4, 32'd4, 0);
    wait_done("gap", 1, 0, 1000, cyc);
    lit("gap_done_cycle", cyc, 484);
    lit("gap_fc", fc_b, 2);

    // asynchronous reset mid-byte
    go(0, 0, 1, 0, 8'h02, 32'd0, 32'd9, 32'd1, 0);
    repeat (50) @(negedge clk);
    lit("pre_reset_tx_low", tx_a, 0);
    #2 rst_n = 1'b0;
    #1;
    lit("async_reset_tx", tx_a, 1);
    lit("async_reset_busy", busy_a, 0);
    lit("async_reset_fc", fc_a, 0);
    q_a.delete(); q_b.delete();
    last_fc_a = 16'd0; last_fc_b = 16'd0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // empty range: busy one cycle, done next
    go(0, 0, 1, 0, 8'h04, 32'd10, 32'd5, 32'd1, 0);
    wait_done("empty", 0, 0, 50, cyc);
    lit("empty_done_cycle", cyc, 2);
    lit("empty_fc", fc_a, 0);

    // fresh sweep after reset
    go(0, 0, 1, 0, 8'h09, 32'd1, 32'd1, 32'd1, 0);
    wait_done("fresh", 0, 0, 1000, cyc);
    lit("fresh_done_cycle", cyc, 201);
    lit("fresh_fc", fc_a, 1);

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_peek_sweeper.md
UART_PEEK_SWEEPER -- requirements
Module: uart_peek_sweeper

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, meaning clk cycles per UART bit (>=2).
REQ-002 SHALL have parameter ID_W, default 8, meaning width of the peek target ID.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning width of the peek address; ID_W+ADDR_W SHALL be a multiple of 8.
REQ-004 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts an even-parity bit after the data bits.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per byte (1 or 2).
REQ-006 SHALL have parameter GAP_CYCLES, default 0, meaning idle-high clk cycles between consecutive frames.
REQ-007 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-010 SHALL have port abort  input  1  request to stop after the frame in flight.
REQ-011 SHALL have port id  input  ID_W  peek target ID, sampled on accepted start.
REQ-012 SHALL have port addr_lo  input  ADDR_W  first address, sampled on accepted start.
REQ-013 SHALL have port addr_hi  input  ADDR_W  last address (inclusive), sampled on accepted start.
REQ-014 SHALL have port step  input  ADDR_W  address increment, sampled on accepted start.
REQ-015 SHALL have port tx  output  1  UART serial line, idle high.
REQ-016 SHALL have port bit_tick  output  1  one-cycle pulse at the start of every transmitted bit.
REQ-017 SHALL have port busy  output  1  high from accepted start until done.
REQ-018 SHALL have port done  output  1  one-cycle pulse when the sweep ends.
REQ-019 SHALL have port frame_cnt  output  16  frames fully sent in the current or last sweep.

Function
REQ-020 SHALL accept start only when busy=0; start while busy is ignored.
REQ-021 SHALL send one frame per address: NB=(ID_W+ADDR_W)/8 bytes of {id,addr}, least significant byte first (addr bytes, then id bytes).
REQ-022 SHALL send each byte as start bit 0, 8 data bits LSB first, parity bit (if PARITY_EN, even over 8 data bits), then STOP_BITS stop bits of 1.
REQ-023 SHALL hold every bit on tx for exactly CLK_DIV clk cycles; bytes within a frame SHALL be back-to-back with no idle.
REQ-024 SHALL drive tx low (first start bit) on the cycle after start is accepted, with bit_tick high that cycle.
REQ-025 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, GAP; PARITY skipped when PARITY_EN=0; GAP skipped when GAP_CYCLES=0.
REQ-026 SHALL, after the last stop bit of a frame, increment frame_cnt and compute next=addr+step at ADDR_W+1 bits.
REQ-027 SHALL end the sweep when next>addr_hi, the addition carries out of ADDR_W (no wrap-around), step=0, or abort was seen during the frame.
REQ-028 SHALL otherwise enter GAP for GAP_CYCLES cycles with tx=1, then start the next frame at address next.
REQ-029 SHALL, on sweep end, pulse done for one cycle on the cycle after the final stop bit, clear busy that same cycle, and not insert GAP.
REQ-030 SHALL, when addr_lo>addr_hi at start, send no frame, leave frame_cnt=0, hold busy for one cycle and pulse done on the next cycle.
REQ-031 SHALL latch abort while busy; abort never truncates a byte or frame; abort when idle is ignored.
REQ-032 SHALL clear frame_cnt to 0 on each accepted start; frame_cnt saturates at 16'hFFFF.
REQ-033 SHALL take frame duration NB*(9+PARITY_EN+STOP_BITS)*CLK_DIV clk cycles.

Reset
REQ-034 SHALL, while rst_n=0, force tx=1, bit_tick=0, busy=0, done=0, frame_cnt=0, FSM=IDLE, clear latched abort, independent of clk.
REQ-035 SHALL, on reset mid-frame, abandon the frame immediately with tx high; first accepted start after release begins a fresh sweep.

Verification (CLK_DIV=4, ID_W=8, ADDR_W=32, PARITY_EN=0, STOP_BITS=1, GAP_CYCLES=0 unless stated)
REQ-036 SHALL cover start id=3 lo=572 hi=574 step=1 -> 3 frames, first bytes 3C 02 00 00 03, each frame 200 cycles, frame_cnt=3, done at cycle 601 after start.
REQ-037 SHALL cover PARITY_EN=1 STOP_BITS=2 id=8'h81 lo=hi=32'h00000007 -> byte0 bits 0,11100000,1,11; id byte parity 0; one frame of 240 cycles.
REQ-038 SHALL cover lo=32'hFFFFFFFE hi=32'hFFFFFFFF step=4 -> exactly 1 frame (carry ends sweep), done pulses, no wrap to low addresses.
REQ-039 SHALL cover abort pulsed mid-byte of frame 2 of a 10-frame sweep -> frame 2 completes, frame_cnt=2, done pulses, tx stays 1 afterwards.
REQ-040 SHALL cover rst_n low mid-byte -> tx=1 and busy=0 asynchronously; start while busy and lo>hi (done after one cycle, frame_cnt=0) both checked.
